pe_hist_tile_sequencer: RTL and testbench

Sequencer in front of the PE histogram stage.
- Collects per-lane bit vectors and multiplied signs from a valid/ready stream into a batch of LANES entries.
- Reduces each batch into signed per-position counts and accumulates BATCHES batches into one tile result.
- Presents the tile result on a valid/ready output for the alignment stage. Sits between the operand/sign generator and the alignment logic inside the PE.

---
 rtl/pe_hist_tile_sequencer.sv | 170 +++++++++++++++++
 tb/tb_pe_hist_tile_sequencer.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/pe_hist_tile_sequencer.sv
// Batches lane bit vectors and signs, reduces each batch into signed per-position counts,
// and accumulates them into a tile result. Define PE_HIST_SAT_EN for saturating accumulation.
module pe_hist_tile_sequencer #(
    parameter int unsigned LANES   = 16,
    parameter int unsigned POS     = 16,
    parameter int unsigned BATCHES = 4,
    parameter int unsigned ACC_W   = 8
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic                                 in_valid,
    output logic                                 in_ready,
    input  logic [POS-1:0]                       in_vec,
    input  logic                                 in_sign,
    input  logic                                 in_last,
    output logic                                 out_valid,
    input  logic                                 out_ready,
    output logic [POS*ACC_W-1:0]                 out_hist,
    output logic [$clog2(LANES*BATCHES+1)-1:0]   out_count
);

    localparam int unsigned CW = $clog2(LANES * BATCHES + 1);
    localparam int unsigned LW = (LANES > 1) ? $clog2(LANES) : 1;
    localparam int unsigned BW = (BATCHES > 1) ? $clog2(BATCHES) : 1;
    localparam int unsigned DW = $clog2(LANES + 1) + 1;
    localparam int unsigned SW = ACC_W + DW;

    localparam logic signed [DW-1:0] DOne = DW'(1);

    typedef enum logic [1:0] {StFill, StReduce, StOut} state_e;

    state_e                  state_q, state_d;
    logic [POS-1:0]          vec_q [LANES];
    logic [LANES-1:0]        sign_q;
    logic [LANES-1:0]        mask_q;
    logic [LW-1:0]           lane_cnt_q;
    logic [BW-1:0]           batch_cnt_q;
    logic                    last_q;
    logic signed [ACC_W-1:0] acc_q [POS];
    logic signed [ACC_W-1:0] acc_d [POS];
    logic [CW-1:0]           cnt_q;
    logic [CW-1:0]           pop;
    logic                    accept;
    logic                    batch_close;

    assign accept      = in_valid && in_ready;
    assign batch_close = accept && ((lane_cnt_q == LW'(LANES - 1)) || in_last);

    always_comb begin
        state_d   = state_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        unique case (state_q)
            StFill: begin
                in_ready = 1'b1;
                if (batch_close) begin
                    state_d = StReduce;
                end
            end
            StReduce: begin
                if (last_q || (batch_cnt_q == BW'(BATCHES - 1))) begin
                    state_d = StOut;
                end else begin
                    state_d = StFill;
                end
            end
            StOut: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_d = StFill;
                end
            end
            default: state_d = StFill;
        endcase
    end

    // Per-position batch reduction and accumulate, widened so the clamp sees the true sum.
    always_comb begin
        logic signed [DW-1:0] delta;
        logic signed [SW-1:0] sum;
        pop = '0;
        for (int l = 0; l < LANES; l++) begin
            pop = pop + CW'(mask_q[l]);
        end
        for (int p = 0; p < POS; p++) begin
            delta = '0;
            for (int l = 0; l < LANES; l++) begin
                if (mask_q[l] && vec_q[l][p]) begin
                    delta = sign_q[l] ? (delta - DOne) : (delta + DOne);
                end
            end
            sum = SW'(acc_q[p]) + SW'(delta);
`ifdef PE_HIST_SAT_EN
            if (sum > SW'((2 ** (ACC_W - 1)) - 1)) begin
                acc_d[p] = ACC_W'((2 ** (ACC_W - 1)) - 1);
            end else if (sum < SW'(-(2 ** (ACC_W - 1)))) begin
                acc_d[p] = ACC_W'(-(2 ** (ACC_W - 1)));
            end else begin
                acc_d[p] = ACC_W'(sum);
            end
`else
            acc_d[p] = ACC_W'(sum);
`endif
        end
    end

    always_comb begin
        out_hist = '0;
        for (int p = 0; p < POS; p++) begin
            out_hist[p*ACC_W +: ACC_W] = acc_q[p];
        end
        out_count = cnt_q;
    end

    // Lane payload needs no reset: the mask decides which slots count.
    always_ff @(posedge clk) begin
        if (accept) begin
            vec_q[lane_cnt_q]  <= in_vec;
            sign_q[lane_cnt_q] <= in_sign;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= StFill;
            mask_q      <= '0;
            lane_cnt_q  <= '0;
            batch_cnt_q <= '0;
            last_q      <= 1'b0;
            cnt_q       <= '0;
            for (int p = 0; p < POS; p++) begin
                acc_q[p] <= '0;
            end
        end else begin
            state_q <= state_d;
            unique case (state_q)
                StFill: begin
                    if (accept) begin
                        mask_q[lane_cnt_q] <= 1'b1;
                        lane_cnt_q         <= lane_cnt_q + LW'(1);
                        if (in_last) begin
                            last_q <= 1'b1;
                        end
                    end
                end
                StReduce: begin
                    for (int p = 0; p < POS; p++) begin
                        acc_q[p] <= acc_d[p];
                    end
                    cnt_q       <= cnt_q + pop;
                    mask_q      <= '0;
                    lane_cnt_q  <= '0;
                    batch_cnt_q <= batch_cnt_q + BW'(1);
                end
                StOut: begin
                    if (out_ready) begin
                        for (int p = 0; p < POS; p++) begin
                            acc_q[p] <= '0;
                        end
                        cnt_q       <= '0;
                        batch_cnt_q <= '0;
                        last_q      <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_pe_hist_tile_sequencer.sv
// Directed bench for pe_hist_tile_sequencer: default instance plus an ACC_W=4 instance for
// the accumulator overflow case (expectation follows PE_HIST_SAT_EN).
module tb_pe_hist_tile_sequencer;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid, in_valid_b;
    logic [15:0]  in_vec;
    logic         in_sign, in_last, out_ready;
    logic         in_ready, out_valid, in_ready_b, out_valid_b;
    logic [127:0] out_hist;
    logic [63:0]  out_hist_b;
    logic [6:0]   out_count, out_count_b;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    pe_hist_tile_sequencer dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_vec    (in_vec),
        .in_sign   (in_sign),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_hist  (out_hist),
        .out_count (out_count)
    );

    pe_hist_tile_sequencer #(.ACC_W(4)) dut_b (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid_b),
        .in_ready  (in_ready_b),
        .in_vec    (in_vec),
        .in_sign   (in_sign),
        .in_last   (in_last),
        .out_valid (out_valid_b),
        .out_ready (out_ready),
        .out_hist  (out_hist_b),
        .out_count (out_count_b)
    );

    typedef struct {
        logic [15:0]  va;
        logic         sa;
        int           na;
        logic [15:0]  vb;
        logic         sb;
        int           nb;
        logic         last;
        int           hold;
        int           exp_stall;
        logic [127:0] exp_hist;
        int           exp_cnt;
    } vec_t;

    vec_t tv [6];

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [127:0] put(input logic [127:0] h, input int p, input int v);
        logic [127:0] r;
        logic [7:0]   f;
        r = h;
        f = 8'(v);
        r[p*8 +: 8] = f;
        return r;
    endfunction

    // Called at a negedge; returns at the negedge after the beat is accepted.
    task automatic send(input bit b, input logic [15:0] v, input logic s, input logic l,
                        inout int stalls);
        int guard;
        in_vec  = v;
        in_sign = s;
        in_last = l;
        if (b) in_valid_b = 1'b1; else in_valid = 1'b1;
        guard = 0;
        while (!(b ? in_ready_b : in_ready) && guard < 50) begin
            @(negedge clk);
            guard++;
            stalls++;
        end
        if (guard >= 50) chk("send_timeout", 128'(guard), 128'(0));
        @(negedge clk);
        in_valid   = 1'b0;
        in_valid_b = 1'b0;
        in_last    = 1'b0;
    endtask

    task automatic wait_out(input bit b, input string name);
        int w;
        w = 0;
        while (!(b ? out_valid_b : out_valid) && w < 100) begin
            chk({name, "_reduce_ready"}, 128'(b ? in_ready_b : in_ready), 128'(0));
            @(negedge clk);
            w++;
        end
        chk({name, "_latency"}, 128'(w), 128'(1));
    endtask

    task automatic release_out(input string name);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk({name, "_valid_drop"}, 128'(out_valid), 128'(0));
        chk({name, "_ready_back"}, 128'(in_ready), 128'(1));
    endtask

    initial begin
        int     stalls;
        logic [127:0] h;

        // Test 1: lanes 0-7 A005 negative, lanes 8-15 6003 positive.
        h = put(put(put(put(128'd0, 1, 8), 2, -8), 14, 8), 15, -8);
        tv[0] = '{16'hA005, 1'b1, 8, 16'h6003, 1'b0, 8, 1'b1, 10, 0, h, 16};
        // Accumulators must be clear after the held tile drains.
        tv[1] = '{16'h0002, 1'b0, 1, 16'h0000, 1'b0, 0, 1'b1, 0, 0, put(128'd0, 1, 1), 1};
        // Four full batches, no in_last.
        h = '0;
        for (int p = 0; p < 16; p++) h = put(h, p, 64);
        tv[2] = '{16'hFFFF, 1'b0, 64, 16'h0000, 1'b0, 0, 1'b0, 0, 3, h, 64};
        tv[3] = '{16'h0001, 1'b1, 3, 16'h0000, 1'b0, 0, 1'b1, 0, 0, put(128'd0, 0, -3), 3};
        // in_last on first beat of the second batch gives a 1-lane batch.
        tv[4] = '{16'h0001, 1'b0, 16, 16'h0003, 1'b1, 1, 1'b1, 0, 1,
                  put(put(128'd0, 0, 15), 1, -1), 17};
        h = '0;
        for (int p = 0; p < 4; p++) h = put(h, p, 3);
        for (int p = 4; p < 8; p++) h = put(h, p, -2);
        for (int p = 8; p < 12; p++) h = put(h, p, 5);
        tv[5] = '{16'h0F0F, 1'b0, 5, 16'h00FF, 1'b1, 2, 1'b1, 0, 0, h, 7};

        rst_n      = 1'b0;
        in_valid   = 1'b0;
        in_valid_b = 1'b0;
        in_vec     = '0;
        in_sign    = 1'b0;
        in_last    = 1'b0;
        out_ready  = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        chk("rst_out_valid", 128'(out_valid), 128'(0));
        chk("rst_in_ready", 128'(in_ready), 128'(1));
        chk("rst_count", 128'(out_count), 128'(0));
        chk("rst_hist", out_hist, 128'(0));

        for (int i = 0; i < 6; i++) begin
            stalls = 0;
            for (int j = 0; j < tv[i].na; j++)
                send(1'b0, tv[i].va, tv[i].sa,
                     tv[i].last && tv[i].nb == 0 && j == tv[i].na - 1, stalls);
            for (int j = 0; j < tv[i].nb; j++)
                send(1'b0, tv[i].vb, tv[i].sb, tv[i].last && j == tv[i].nb - 1, stalls);
            chk($sformatf("v%0d_stalls", i), 128'(stalls), 128'(tv[i].exp_stall));
            wait_out(1'b0, $sformatf("v%0d", i));
            chk($sformatf("v%0d_hist", i), out_hist, tv[i].exp_hist);
            chk($sformatf("v%0d_count", i), 128'(out_count), 128'(tv[i].exp_cnt));
            chk($sformatf("v%0d_in_ready", i), 128'(in_ready), 128'(0));
            // Backpressure: offered beats must be ignored and the result held.
            if (tv[i].hold > 0) begin
                in_valid = 1'b1;
                in_vec   = 16'hFFFF;
                in_last  = 1'b1;
                for (int c = 0; c < tv[i].hold; c++) begin
                    @(negedge clk);
                    chk("hold_valid", 128'(out_valid), 128'(1));
                    chk("hold_hist", out_hist, tv[i].exp_hist);
                    chk("hold_ready", 128'(in_ready), 128'(0));
                end
                in_valid = 1'b0;
                in_last  = 1'b0;
                chk("hold_count", 128'(out_count), 128'(tv[i].exp_cnt));
            end
            release_out($sformatf("v%0d", i));
        end

        // Mid-tile reset discards partial data.
        stalls = 0;
        for (int j = 0; j < 5; j++) send(1'b0, 16'hFFFF, 1'b0, 1'b0, stalls);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        chk("mrst_in_ready", 128'(in_ready), 128'(1));
        chk("mrst_valid", 128'(out_valid), 128'(0));
        send(1'b0, 16'h8000, 1'b0, 1'b1, stalls);
        wait_out(1'b0, "mrst");
        chk("mrst_hist", out_hist, put(128'd0, 15, 1));
        chk("mrst_count", 128'(out_count), 128'(1));
        release_out("mrst");

        // ACC_W=4 instance: 16 positive hits on position 0 overflow the accumulator.
        stalls = 0;
        for (int j = 0; j < 16; j++) send(1'b1, 16'h0001, 1'b0, j == 15, stalls);
        wait_out(1'b1, "acc4");
`ifdef PE_HIST_SAT_EN
        chk("acc4_hist", 128'(out_hist_b), 128'(64'h7));
`else
        chk("acc4_hist", 128'(out_hist_b), 128'(64'h0));
`endif
        chk("acc4_count", 128'(out_count_b), 128'(16));
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk("acc4_drop", 128'(out_valid_b), 128'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
